// File: rtl/shift141_seq.sv
// Sequencer for a chain of mc10141 universal shift-register slices: optional
// parallel load, `count` shift cycles with end-fill selection, then HOLD + done.
module shift141_seq #(
    parameter int unsigned CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            ld,
    input  logic            dir,
    input  logic [1:0]      fill,
    input  logic [CNTW-1:0] count,
    input  logic            chainQ0,
    input  logic            chainQ3,
    output logic [1:0]      s,
    output logic            d0In,
    output logic            d3In,
    output logic            ack,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_LOAD   = 2'd0,
        M_SHIFTL = 2'd1,
        M_SHIFTR = 2'd2,
        M_HOLD   = 2'd3
    } mode_t;

    state_t          state, state_next;
    mode_t           mode_q, mode_next;
    logic            dir_q, dir_next;
    logic [1:0]      fill_q, fill_next;
    logic [CNTW-1:0] rem, rem_next;
    logic            ack_next, busy_next, done_next;
    logic            fill_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            mode_q <= M_HOLD;
            dir_q  <= 1'b0;
            fill_q <= '0;
            rem    <= '0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            mode_q <= mode_next;
            dir_q  <= dir_next;
            fill_q <= fill_next;
            rem    <= rem_next;
            ack    <= ack_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_q;
        fill_next  = fill_q;
        rem_next   = rem;
        ack_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    ack_next  = 1'b1;
                    dir_next  = dir;
                    fill_next = fill;
                    rem_next  = count;
                    if (ld)
                        state_next = ST_LOAD;
                    else if (count != '0)
                        state_next = ST_SHIFT;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_LOAD:
                state_next = (rem != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: begin
                // Saturating decrement; exit on the edge that takes rem to zero.
                if (rem != '0)
                    rem_next = rem - CNTW'(1);
                if (rem <= CNTW'(1))
                    state_next = ST_DONE;
            end
            ST_DONE:
                state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase

        // Mode and status are registered from the next state so `s` never glitches.
        case (state_next)
            ST_LOAD:  mode_next = M_LOAD;
            ST_SHIFT: mode_next = dir_next ? M_SHIFTR : M_SHIFTL;
            default:  mode_next = M_HOLD;
        endcase
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_comb begin
        fill_bit = 1'b0;
        case (fill_q)
            2'b00: fill_bit = 1'b0;
            2'b01: fill_bit = 1'b1;
            2'b10: fill_bit = dir_q ? chainQ0 : chainQ3;
            2'b11: fill_bit = dir_q ? 1'b0 : chainQ0;
            default: fill_bit = 1'b0;
        endcase
    end

    assign s    = mode_q;
    assign d0In = (state == ST_SHIFT) && !dir_q && fill_bit;
    assign d3In = (state == ST_SHIFT) && dir_q && fill_bit;

endmodule

// File: doc/shift141_seq.md
# shift141_seq

Sequencer for a chain of mc10141 4-bit universal shift-register slices. It accepts one shift request at a time, optionally loads the chain in parallel, and drives the shared mode select for exactly `count` shift cycles. During those cycles it supplies the serial fill bits at both chain ends: zero, one, rotate or sign-replicate. It then parks the chain in HOLD and pulses `done`. It sits between microcode-level control and any mc10141 chain used as a shifter or bit counter.

## Interface
Parameters:
- `CNTW`, default 6: width of the shift count; maximum count is 2^CNTW−1.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request a shift operation; sampled only in IDLE.
- `ld`  in  1  with `req`: perform one LOAD cycle before shifting.
- `dir`  in  1  with `req`: 0 = SHIFTL (data moves q0→q3, enters at d0In), 1 = SHIFTR (data moves q3→q0, enters at d3In).
- `fill`  in  2  with `req`: 00 zero, 01 one, 10 rotate, 11 arithmetic.
- `count`  in  CNTW  with `req`: number of shift cycles.
- `chainQ0`  in  1  q0 of the most-significant slice (chain end bit 0).
- `chainQ3`  in  1  q3 of the least-significant slice (chain end bit 3).
- `s`  out  2  tMode141 mode to all slices: LOAD=0, SHIFTL=1, SHIFTR=2, HOLD=3.
- `d0In`  out  1  serial input at the q0 end of the chain.
- `d3In`  out  1  serial input at the q3 end of the chain.
- `ack`  out  1  one-cycle pulse; request accepted.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; the operation is complete and the chain is holding.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Outputs: `s`=HOLD, `busy`=0.
  - `req`=1 at an edge is accepted: `dir`, `fill`, `ld` and `count` are latched, and `ack`=1 for the following cycle.
  - Next state: LOAD if `ld`=1; else SHIFT if `count`≠0; else DONE.
- LOAD: `s`=LOAD for exactly one cycle. Next state is SHIFT if the latched count ≠0, else DONE.
- SHIFT:
  - `s`=SHIFTL or SHIFTR according to the latched `dir`.
  - A remaining-count register is loaded with `count` on acceptance and decrements at each SHIFT-cycle edge.
  - Leave for DONE at the edge where remaining reaches 0. This gives exactly `count` SHIFT cycles.
- DONE: `s`=HOLD, `done`=1, `busy`=1, for one cycle. Next state is IDLE.
- Fill bits (combinational from the latched `fill`/`dir` and the chain inputs):
  - Both are valid only in SHIFT. Outside SHIFT, `d0In`=`d3In`=0.
  - The end that is not the shift input is always 0.
  - SHIFTL: `d0In` = 0, 1, `chainQ3` (rotate), `chainQ0` (arithmetic: sign replicate).
  - SHIFTR: `d3In` = 0, 1, `chainQ0` (rotate), 0 (arithmetic: zero fill).
- `req` while not in IDLE, including the DONE cycle, is ignored and not queued. It is accepted in the first IDLE cycle if still asserted.
- `req` inputs other than `req` itself are don't-care except at the accepting edge.
- `reset`:
  - Forces IDLE at the next edge from any state, aborting any operation in progress.
  - Reset values: `s`=HOLD, `ack`=0, `busy`=0, `done`=0, `d0In`=0, `d3In`=0, remaining count = 0.
  - No `done` is issued for an aborted operation.

## Timing
- Edge E0 accepts the request. Cycle E0→E1 carries `ack`=1, `busy`=1.
- With `ld`=1, the LOAD cycle spans E0→E1 and the chain captures d at E1. Shift edges follow.
- Total `busy` cycles = `ld` + `count` + 1. `done` occurs in the last of them.
- Minimum operation (`ld`=0, `count`=0): a single DONE cycle, so `ack` and `done` are high in the same cycle.
- Back-to-back requests: the next acceptance occurs no earlier than 1 cycle after DONE (one IDLE cycle minimum).
- `count`=2^CNTW−1 must complete without wrap. The remaining count never underflows.
- `s` is registered and glitch-free. `d0In`/`d3In` may follow the chain inputs within a cycle and settle before the edge.

## Test plan
- Bench setup: one mc10141 with q0→`chainQ0` and q3→`chainQ3`.
- Reset, then `req` `ld`=1 with d=1010, `count`=0 → `s` sequence HOLD,LOAD,HOLD; `done` in cycle 2; q=1010; `busy` high exactly 2 cycles.
- Load 0000, then SHIFTR `fill`=01 `count`=3 → q=0001,0011,0111 on successive edges; `d0In`=0 throughout; `done` after the third shift.
- Load 1000, then SHIFTL rotate `count`=4 → q=0100,0010,0001,1000; the final value equals the start value.
- Load 1010, then SHIFTL arithmetic `count`=2 → q=1101 then 1110 (sign replicated).
- `req` held high during busy → no second `ack` until one cycle after `done`. Then `count`=5 is accepted and shifts exactly 5 times.
- `reset` asserted in the 2nd SHIFT cycle of a `count`=6 operation → next cycle `s`=HOLD, `busy`=0, no `done`; q frozen at its 2-shift value.
